clock_time_counter: RTL and testbench

BCD time-of-day counter that holds hours, minutes and seconds and drives the serial display output stage directly downstream. It advances on a 1 Hz strobe and accepts minute/hour set strobes from the button logic. It also generates the colon decimal points. It issues a refresh start strobe to the display serializer whenever shown content changes, handshaking against that stage's busy flag so no update is lost or issued mid-shift.

---
 rtl/clock_time_counter_if.sv | 28 ++
 rtl/clock_time_counter.sv | 184 ++++++++++++++++++
 tb/tb_clock_time_counter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/clock_time_counter_if.sv
// Display-side bundle between the time counter and the serial display stage:
// BCD digits, decimal points, enable copy and the refresh start/busy handshake.
interface clock_time_counter_if;
  logic [3:0] hours_msb;
  logic [3:0] hours_lsb;
  logic [3:0] minutes_msb;
  logic [3:0] minutes_lsb;
  logic [3:0] seconds_msb;
  logic [3:0] seconds_lsb;
  logic [5:0] dp;
  logic       display_en;
  logic       refresh_stb;
  logic       busy;

  // Counter side: drives the shown content and the start strobe.
  modport master (
    output hours_msb, hours_lsb, minutes_msb, minutes_lsb,
    output seconds_msb, seconds_lsb, dp, display_en, refresh_stb,
    input  busy
  );

  // Serializer side: consumes content, reports when it is shifting.
  modport slave (
    input  hours_msb, hours_lsb, minutes_msb, minutes_lsb,
    input  seconds_msb, seconds_lsb, dp, display_en, refresh_stb,
    output busy
  );
endinterface

// File: rtl/clock_time_counter.sv
// BCD time-of-day counter (HH:MM:SS) with set buttons, colon decimal points
// and a refresh handshake towards the display serializer. Any change to the
// shown content raises a pending request; the FSM turns pending requests into
// a single start strobe once the serializer is idle.
module clock_time_counter #(
  parameter int ACK_TIMEOUT = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sec_stb,
  input  logic i_set_min_stb,
  input  logic i_set_hr_stb,
  input  logic i_display_en,
  clock_time_counter_if.master disp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    ACK    = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [3:0] TIMER_LAST = 4'(ACK_TIMEOUT - 1);

  // Digit pairs packed as {msb, lsb}
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hr_q,  hr_d;
  logic [5:0] dp_q;
  logic       disp_en_q;
  logic       refresh_stb_q;
  logic       pending_q;
  logic [3:0] timer_q;
  state_t     state_q;

  logic [8:0] sec_inc;
  logic [8:0] min_inc;
  logic [7:0] hr_inc;
  logic       digit_change;
  logic       content_event;

  // Increment a 00..59 BCD pair; bit 8 flags the 59->00 wrap.
  function automatic logic [8:0] inc_sixty(input logic [7:0] v);
    logic [3:0] msb;
    logic [3:0] lsb;
    logic       carry;
    msb   = v[7:4];
    lsb   = v[3:0];
    carry = 1'b0;
    if (lsb == 4'd9) begin
      lsb = 4'd0;
      if (msb == 4'd5) begin
        msb   = 4'd0;
        carry = 1'b1;
      end else begin
        msb = msb + 4'd1;
      end
    end else begin
      lsb = lsb + 4'd1;
    end
    return {carry, msb, lsb};
  endfunction

  // Increment a 00..23 BCD hour pair; the day wrap carries nowhere.
  function automatic logic [7:0] inc_hours(input logic [7:0] v);
    logic [3:0] msb;
    logic [3:0] lsb;
    msb = v[7:4];
    lsb = v[3:0];
    if (v == 8'h23) begin
      msb = 4'd0;
      lsb = 4'd0;
    end else if (lsb == 4'd9) begin
      msb = msb + 4'd1;
      lsb = 4'd0;
    end else begin
      lsb = lsb + 4'd1;
    end
    return {msb, lsb};
  endfunction

  assign sec_inc = inc_sixty(sec_q);
  assign min_inc = inc_sixty(min_q);
  assign hr_inc  = inc_hours(hr_q);

  // Next time value: set strobes take priority and swallow a coincident tick.
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (i_set_min_stb || i_set_hr_stb) begin
      if (i_set_min_stb) begin
        min_d = min_inc[7:0];
        sec_d = 8'h00;
      end
      if (i_set_hr_stb) begin
        hr_d = hr_inc;
      end
    end else if (i_sec_stb) begin
      sec_d = sec_inc[7:0];
      if (sec_inc[8]) begin
        min_d = min_inc[7:0];
        if (min_inc[8]) begin
          hr_d = hr_inc;
        end
      end
    end
  end

  assign digit_change  = (sec_d != sec_q) || (min_d != min_q) || (hr_d != hr_q);
  assign content_event = digit_change || (i_display_en != disp_en_q);

  // Time digits, colon points and the registered display enable.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sec_q     <= 8'h00;
      min_q     <= 8'h00;
      hr_q      <= 8'h00;
      dp_q      <= 6'b010100;
      disp_en_q <= 1'b0;
    end else begin
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      // Colon lit on even seconds
      dp_q      <= {1'b0, ~sec_d[0], 1'b0, ~sec_d[0], 2'b00};
      disp_en_q <= i_display_en;
    end
  end

  // Refresh handshake: coalesce pending changes into one strobe per transfer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      pending_q     <= 1'b1;
      refresh_stb_q <= 1'b0;
      timer_q       <= 4'd0;
    end else begin
      refresh_stb_q <= 1'b0;
      pending_q     <= pending_q | content_event;
      case (state_q)
        IDLE: begin
          if (pending_q && !disp.busy) begin
            state_q       <= STROBE;
            refresh_stb_q <= 1'b1;
          end
        end
        STROBE: begin
          // A change landing on the strobe cycle keeps the request alive
          pending_q <= content_event;
          timer_q   <= 4'd0;
          state_q   <= ACK;
        end
        ACK: begin
          if (disp.busy) begin
            state_q <= DRAIN;
          end else if (timer_q == TIMER_LAST) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 4'd1;
          end
        end
        DRAIN: begin
          if (!disp.busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign disp.hours_msb   = hr_q[7:4];
  assign disp.hours_lsb   = hr_q[3:0];
  assign disp.minutes_msb = min_q[7:4];
  assign disp.minutes_lsb = min_q[3:0];
  assign disp.seconds_msb = sec_q[7:4];
  assign disp.seconds_lsb = sec_q[3:0];
  assign disp.dp          = dp_q;
  assign disp.display_en  = disp_en_q;
  assign disp.refresh_stb = refresh_stb_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter: reset, carries, set priority,
// refresh coalescing under busy, ack timeout, enable toggling and reset in DRAIN.
module tb_clock_time_counter;

  logic clk;
  logic reset;
  logic sec_stb;
  logic set_min_stb;
  logic set_hr_stb;
  logic display_en;

  int total  = 0;
  int passed = 0;
  int stb_cnt = 0;
  int base;
  logic [23:0] seen_time = 24'h0;

  clock_time_counter_if bus ();

  clock_time_counter #(.ACK_TIMEOUT(4)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_sec_stb     (sec_stb),
    .i_set_min_stb (set_min_stb),
    .i_set_hr_stb  (set_hr_stb),
    .i_display_en  (display_en),
    .disp          (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] cur_time();
    return {bus.hours_msb, bus.hours_lsb, bus.minutes_msb, bus.minutes_lsb,
            bus.seconds_msb, bus.seconds_lsb};
  endfunction

  // Serializer view: count strobes and latch the time shown with each one
  always @(negedge clk) begin
    if (bus.refresh_stb === 1'b1) begin
      stb_cnt++;
      seen_time = cur_time();
      $display("refresh strobe #%0d at %0t, time %06h", stb_cnt, $time, seen_time);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; sec_stb = 1'b0; set_min_stb = 1'b0; set_hr_stb = 1'b0;
    display_en = 1'b0; bus.busy = 1'b0;
    step(3);

    // Reset state
    check("reset_time", 32'(cur_time()), 32'h000000);
    check("reset_dp", 32'(bus.dp), 32'b010100);
    check("reset_en", 32'(bus.display_en), 32'd0);
    check("reset_stb", 32'(bus.refresh_stb), 32'd0);

    // Release: strobe one cycle later
    base = stb_cnt;
    reset = 1'b0;
    step();
    check("release_stb", 32'(bus.refresh_stb), 32'd1);
    // Tick during the strobe cycle -> re-arms pending
    sec_stb = 1'b1;
    step();
    sec_stb = 1'b0;
    check("stb_one_cycle", 32'(bus.refresh_stb), 32'd0);
    check("tick_sec", 32'(cur_time()), 32'h000001);
    check("tick_dp", 32'(bus.dp), 32'b000000);
    check("release_count", 32'(stb_cnt - base), 32'd1);
    // ACK timeout of 4 cycles, then the pending tick strobes
    step(4);
    check("timeout_no_stb", 32'(bus.refresh_stb), 32'd0);
    step();
    check("timeout_then_stb", 32'(bus.refresh_stb), 32'd1);
    step(12);

    // Preset to 23:59:59
    set_hr_stb = 1'b1;  step(23); set_hr_stb = 1'b0;
    set_min_stb = 1'b1; step(59); set_min_stb = 1'b0;
    sec_stb = 1'b1;     step(59); sec_stb = 1'b0;
    step(12);
    check("preset_time", 32'(cur_time()), 32'h235959);
    check("preset_dp", 32'(bus.dp), 32'b000000);
    base = stb_cnt;
    sec_stb = 1'b1; step(); sec_stb = 1'b0;
    check("full_carry", 32'(cur_time()), 32'h000000);
    check("full_carry_dp", 32'(bus.dp), 32'b010100);
    step();
    check("full_carry_stb", 32'(bus.refresh_stb), 32'd1);
    step(12);
    check("full_carry_count", 32'(stb_cnt - base), 32'd1);

    // Set priority and set wrap behaviour
    set_hr_stb = 1'b1;  step(12); set_hr_stb = 1'b0;
    set_min_stb = 1'b1; step(34); set_min_stb = 1'b0;
    sec_stb = 1'b1;     step(56); sec_stb = 1'b0;
    check("preset_123456", 32'(cur_time()), 32'h123456);
    set_min_stb = 1'b1; sec_stb = 1'b1; step(); set_min_stb = 1'b0; sec_stb = 1'b0;
    check("set_min_beats_tick", 32'(cur_time()), 32'h123500);
    set_min_stb = 1'b1; step(24); set_min_stb = 1'b0;
    check("min_59", 32'(cur_time()), 32'h125900);
    set_min_stb = 1'b1; step(); set_min_stb = 1'b0;
    check("min_wrap_no_carry", 32'(cur_time()), 32'h120000);
    set_hr_stb = 1'b1; step(11); set_hr_stb = 1'b0;
    sec_stb = 1'b1;    step(7);  sec_stb = 1'b0;
    check("hr_23", 32'(cur_time()), 32'h230007);
    set_hr_stb = 1'b1; step(); set_hr_stb = 1'b0;
    check("hr_wrap", 32'(cur_time()), 32'h000007);
    set_hr_stb = 1'b1; set_min_stb = 1'b1; step(); set_hr_stb = 1'b0; set_min_stb = 1'b0;
    check("both_sets", 32'(cur_time()), 32'h010100);
    step(12);

    // Coalescing under a long busy window
    base = stb_cnt;
    bus.busy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      sec_stb = (i == 100 || i == 200 || i == 300);
      step();
    end
    sec_stb = 1'b0;
    check("busy_no_stb", 32'(stb_cnt - base), 32'd0);
    check("busy_time", 32'(cur_time()), 32'h010103);
    bus.busy = 1'b0;
    step();
    check("busy_release_stb", 32'(bus.refresh_stb), 32'd1);
    bus.busy = 1'b1;
    step(3);
    bus.busy = 1'b0;
    step(12);
    check("coalesce_count", 32'(stb_cnt - base), 32'd1);
    check("coalesce_seen", 32'(seen_time), 32'h010103);

    // Display enable toggle with no time change
    base = stb_cnt;
    display_en = 1'b1;
    check("en_before_edge", 32'(bus.display_en), 32'd0);
    step();
    check("en_follows", 32'(bus.display_en), 32'd1);
    step();
    check("en_stb", 32'(bus.refresh_stb), 32'd1);
    step(12);
    check("en_count", 32'(stb_cnt - base), 32'd1);

    // Reset while in DRAIN
    sec_stb = 1'b1; step(); sec_stb = 1'b0;
    step();
    check("drain_stb", 32'(bus.refresh_stb), 32'd1);
    bus.busy = 1'b1;
    step(3);
    reset = 1'b1;
    step();
    check("drain_reset_stb", 32'(bus.refresh_stb), 32'd0);
    check("drain_reset_time", 32'(cur_time()), 32'h000000);
    base = stb_cnt;
    reset = 1'b0;
    step(3);
    check("post_reset_busy_hold", 32'(stb_cnt - base), 32'd0);
    bus.busy = 1'b0;
    step();
    check("post_reset_stb", 32'(bus.refresh_stb), 32'd1);
    step(12);
    check("post_reset_count", 32'(stb_cnt - base), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
